// File: rtl/frame_source_sequencer_if.sv
// frame_source_sequencer_if: pixel-source and downstream stream bundle for frame_source_sequencer
// Signals:
//   srcN_start      sequencer -> source  start request
//   srcN_start_ack  source -> sequencer  registered echo of start
//   srcN_valid      source -> sequencer  beat valid
//   srcN_ready      sequencer -> source  beat accepted
//   srcN_pixel      source -> sequencer  8-bit pixel
//   out_valid/out_pixel/out_sof/out_eof  sequencer -> downstream
//   out_ready       downstream -> sequencer
// Modports: master = sequencer side, slave = sources/downstream side.
interface frame_source_sequencer_if;
    logic       src0_start, src1_start;
    logic       src0_start_ack, src1_start_ack;
    logic       src0_valid, src1_valid;
    logic       src0_ready, src1_ready;
    logic [7:0] src0_pixel, src1_pixel;
    logic       out_valid, out_ready, out_sof, out_eof;
    logic [7:0] out_pixel;
    modport master (
        output src0_start, src1_start, src0_ready, src1_ready,
        output out_valid, out_pixel, out_sof, out_eof,
        input  src0_start_ack, src1_start_ack, src0_valid, src1_valid,
        input  src0_pixel, src1_pixel, out_ready
    );
    modport slave (
        input  src0_start, src1_start, src0_ready, src1_ready,
        input  out_valid, out_pixel, out_sof, out_eof,
        output src0_start_ack, src1_start_ack, src0_valid, src1_valid,
        output src0_pixel, src1_pixel, out_ready
    );
endinterface

// File: rtl/frame_source_sequencer.sv
// frame_source_sequencer: sequences whole frames from two pixel sources into one downstream stream
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   enable_i       keep sequencing frames while high
//   mode_i         0/3 = src0 only, 1 = src1 only, 2 = alternate starting with src0
//   bus            frame_source_sequencer_if.master (source handshakes, downstream stream)
//   active_src_o   currently selected source
//   busy_o         FSM not idle
//   frame_count_o  completed frames, wrapping
//   err_timeout_o  sticky handshake timeout (only with FRAME_TIMEOUT_EN)
// Optional feature: define FRAME_TIMEOUT_EN to add the REQ/REL handshake watchdog.
module frame_source_sequencer #(
    parameter int FRAME_PIXELS   = 480000,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic [1:0]                     mode_i,
    frame_source_sequencer_if.master       bus,
    output logic                           active_src_o,
    output logic                           busy_o,
    output logic [15:0]                    frame_count_o,
    output logic                           err_timeout_o
);
    localparam int CW = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS - 1);
    typedef enum logic [1:0] {IDLE, REQ, REL, STREAM} state_t;
    state_t        state_q, state_d;
    logic          sel_q, sel_d, next_sel;
    logic [CW-1:0] cnt_q;
    logic [15:0]   fc_q;
    logic          start0_q, start1_q;
    logic          stream, sel_ack, beat, timeout, err_q;
`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wd_q;
    assign timeout = (state_q inside {REQ, REL}) && wd_q == LIM;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        stream         = state_q == STREAM;
        sel_ack        = sel_q ? bus.src1_start_ack : bus.src0_start_ack;
        bus.out_valid  = stream & (sel_q ? bus.src1_valid : bus.src0_valid);
        bus.out_pixel  = stream ? (sel_q ? bus.src1_pixel : bus.src0_pixel) : 8'd0;
        bus.src0_ready = stream & ~sel_q & bus.out_ready;
        bus.src1_ready = stream & sel_q & bus.out_ready;
        bus.out_sof    = stream && cnt_q == '0;
        bus.out_eof    = stream && cnt_q == LAST;
        beat           = bus.out_valid & bus.out_ready;
        next_sel       = mode_i == 2'd2 ? ~sel_q : mode_i == 2'd1;
        state_d        = state_q;
        sel_d          = sel_q;
        case (state_q)
            IDLE: begin
                state_d = enable_i ? REQ : IDLE;
                sel_d   = enable_i ? mode_i == 2'd1 : sel_q;
            end
            REQ:    state_d = sel_ack ? REL : timeout ? IDLE : REQ;
            // The source starts its frame on the falling edge of its ack.
            REL:    state_d = !sel_ack ? STREAM : timeout ? IDLE : REL;
            STREAM: begin
                state_d = (beat && bus.out_eof) ? (enable_i ? REQ : IDLE) : STREAM;
                sel_d   = (beat && bus.out_eof && enable_i) ? next_sel : sel_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            fc_q     <= '0;
            start0_q <= 1'b0;
            start1_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= !stream ? '0 : beat ? cnt_q + 1'b1 : cnt_q;
            fc_q     <= (beat && bus.out_eof) ? fc_q + 16'd1 : fc_q;
            // Start is held only while REQ persists, so it drops on the same edge the ack is seen.
            start0_q <= state_q == REQ && state_d == REQ && !sel_q;
            start1_q <= state_q == REQ && state_d == REQ && sel_q;
`ifdef FRAME_TIMEOUT_EN
            wd_q     <= (state_d != state_q || !(state_q inside {REQ, REL})) ? '0 : wd_q + 1'b1;
            err_q    <= err_q | (timeout && state_d == IDLE);
`else
            err_q    <= 1'b0;
`endif
        end
    end
    assign bus.src0_start  = start0_q;
    assign bus.src1_start  = start1_q;
    assign active_src_o    = sel_q;
    assign busy_o          = state_q != IDLE;
    assign frame_count_o   = fc_q;
    assign err_timeout_o   = err_q;
endmodule

// File: tb/tb_frame_source_sequencer.sv
// tb_frame_source_sequencer: directed self-checking bench with two registered-echo pixel sources
module tb_frame_source_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        active_src, busy, err_timeout;
    logic [15:0] frame_count;
    logic        stuck0 = 1'b0;
    logic        ack0, ack1, act0, act1;
    logic [3:0]  idx0, idx1;
    int          vectors = 0;
    int          miscompares = 0;
    frame_source_sequencer_if bus();
    frame_source_sequencer #(.FRAME_PIXELS(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .bus(bus),
        .active_src_o(active_src), .busy_o(busy), .frame_count_o(frame_count),
        .err_timeout_o(err_timeout)
    );
    always #5 clk = ~clk;
    // Sources: ack is a registered echo of start; a frame of 16 beats begins as ack falls.
    always @(posedge clk) begin
        if (rst) begin
            ack0 <= 1'b0; act0 <= 1'b0; idx0 <= '0;
            ack1 <= 1'b0; act1 <= 1'b0; idx1 <= '0;
        end else begin
            ack0 <= stuck0 ? 1'b0 : bus.src0_start;
            ack1 <= bus.src1_start;
            if (ack0 && !bus.src0_start) begin act0 <= 1'b1; idx0 <= '0; end
            else if (act0 && bus.src0_ready) begin idx0 <= idx0 + 1'b1; act0 <= idx0 != 4'd15; end
            if (ack1 && !bus.src1_start) begin act1 <= 1'b1; idx1 <= '0; end
            else if (act1 && bus.src1_ready) begin idx1 <= idx1 + 1'b1; act1 <= idx1 != 4'd15; end
        end
    end
    assign bus.src0_start_ack = ack0;
    assign bus.src1_start_ack = ack1;
    assign bus.src0_valid     = act0;
    assign bus.src1_valid     = act1;
    assign bus.src0_pixel     = 8'h10 + {4'd0, idx0};
    assign bus.src1_pixel     = 8'h80 + {4'd0, idx1};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_idle(input string tag, input logic [15:0] fc);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start0"}, bus.src0_start, 0);
        check({tag, "_start1"}, bus.src1_start, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_rdy"}, {bus.src0_ready, bus.src1_ready}, 0);
        check({tag, "_pix"}, bus.out_pixel, 0);
        check({tag, "_fc"}, frame_count, fc);
    endtask
    // Collects one frame from the expected source, checking every beat and both ready lines.
    task automatic get_frame(input logic src, input bit rnd, input int drop_at, input int abort_at);
        int n;
        n = 0;
        for (int c = 0; c < 300 && n < 16; c++) begin
            @(negedge clk);
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("other_ready", src ? bus.src0_ready : bus.src1_ready, 0);
            if (bus.out_valid) check("sel_ready", src ? bus.src1_ready : bus.src0_ready, bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                check("pixel", bus.out_pixel, (src ? 32'h80 : 32'h10) + n);
                check("active_src", active_src, src);
                check("sof", bus.out_sof, n == 0);
                check("eof", bus.out_eof, n == 15);
                if (n == drop_at) enable = 1'b0;
                if (n == abort_at) begin
                    rst = 1'b1;
                    enable = 1'b0;
                    return;
                end
                n++;
            end
        end
        check("beats", n, 16);
    endtask
    initial begin
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset", 16'd0);
        check("reset_sof", {bus.out_sof, bus.out_eof}, 0);
        check("reset_act", active_src, 0);
        check("reset_err", err_timeout, 0);
        rst = 1'b0;
        // mode 0, start timing, enable dropped at beat 5
        enable = 1'b1;
        mode = 2'd0;
        @(negedge clk);
        check("t0_busy", busy, 1);
        check("t0_start0", bus.src0_start, 0);
        @(negedge clk);
        check("t1_start0", bus.src0_start, 1);
        check("t1_start1", bus.src1_start, 0);
        get_frame(1'b0, 1'b0, 5, -1);
        @(negedge clk);
        check_idle("drop", 16'd1);
        repeat (4) @(negedge clk);
        check_idle("drop_late", 16'd1);
        // mode 2 alternation over three frames, middle one with random backpressure
        mode = 2'd2;
        enable = 1'b1;
        get_frame(1'b0, 1'b0, -1, -1);
        @(negedge clk);
        check("alt_fc1", frame_count, 2);
        get_frame(1'b1, 1'b1, -1, -1);
        @(negedge clk);
        check("alt_fc2", frame_count, 3);
        get_frame(1'b0, 1'b0, 10, -1);
        @(negedge clk);
        check_idle("alt_end", 16'd4);
        // mode 1 with random backpressure
        mode = 2'd1;
        enable = 1'b1;
        get_frame(1'b1, 1'b1, 0, -1);
        @(negedge clk);
        check_idle("m1_end", 16'd5);
        // reset at beat 7 abandons the frame
        mode = 2'd0;
        enable = 1'b1;
        get_frame(1'b0, 1'b0, -1, 7);
        @(negedge clk);
        check_idle("rst_mid", 16'd0);
        rst = 1'b0;
        // source whose ack never rises
        stuck0 = 1'b1;
        enable = 1'b1;
`ifdef FRAME_TIMEOUT_EN
        begin
            int highs;
            bit seen;
            highs = 0;
            seen = 1'b0;
            for (int c = 0; c < 50 && !(seen && !bus.src0_start); c++) begin
                @(negedge clk);
                if (bus.src0_start) begin highs++; seen = 1'b1; end
            end
            enable = 1'b0;
            check("to_highs", highs, 7);
            check("to_err", err_timeout, 1);
            repeat (5) @(negedge clk);
            check("to_err_sticky", err_timeout, 1);
        end
`else
        repeat (20) @(negedge clk);
        check("stuck_start", bus.src0_start, 1);
        check("stuck_busy", busy, 1);
        check("stuck_err", err_timeout, 0);
        enable = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        check("final_err", err_timeout, 0);
        check_idle("final", 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
